// File: rtl/pass_hls_deadlock_report_ctrl_pkg.sv
// Shared types for the HLS deadlock report controller.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package pass_hls_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_ORIGIN,
        ST_TRACE,
        ST_REPORT
    } dl_ctrl_state_t;

    // Width of a process index; never narrower than one bit.
    function automatic int proc_id_w(input int proc_num);
        return (proc_num > 1) ? $clog2(proc_num) : 1;
    endfunction

endpackage

// File: rtl/pass_hls_deadlock_report_ctrl_prio_enc.sv
// Lowest-index priority encoder over the detection request vector.
// Latency: combinational.
// Backpressure: none.
module pass_hls_dl_prio_enc
    import pass_hls_dl_pkg::*;
#(
    parameter int PROC_NUM  = 4,
    parameter int PROC_ID_W = proc_id_w(PROC_NUM)
) (
    input  logic [PROC_NUM-1:0]  req,
    output logic [PROC_ID_W-1:0] idx,
    output logic                 found
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        found = |req;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (req[i]) idx = PROC_ID_W'(i);
        end
    end

endmodule

// File: rtl/pass_hls_deadlock_report_ctrl.sv
// Sequencer that confirms a deadlock candidate, traces one token and publishes a report.
// Latency: CONFIRM_CYCLES+1 cycles from candidate to token launch; report one cycle after loop closure.
// Backpressure: the report is held until report_ack; optional trace abort with macro PASS_HLS_DL_REPORT_TIMEOUT_EN.
module pass_hls_deadlock_report_ctrl
    import pass_hls_dl_pkg::*;
#(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [PROC_NUM-1:0]            dl_detect_vec,
    output logic                           dl_detect_in,
    output logic [PROC_NUM-1:0]            origin_vec,
    output logic                           token_clear,
    output logic                           report_valid,
    output logic [proc_id_w(PROC_NUM)-1:0] report_proc_id,
    output logic [PROC_NUM-1:0]            report_path_vec,
    input  logic                           report_ack,
    output logic                           dl_timeout
);

    localparam int PROC_ID_W = proc_id_w(PROC_NUM);
    localparam int CONF_W    = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;

    dl_ctrl_state_t        state;
    logic [PROC_ID_W-1:0]  cand;
    logic [CONF_W-1:0]     conf_cnt;
    logic [PROC_NUM-1:0]   path;
    logic [PROC_ID_W-1:0]  enc_idx;
    logic                  enc_found;

    pass_hls_dl_prio_enc #(
        .PROC_NUM  (PROC_NUM),
        .PROC_ID_W (PROC_ID_W)
    ) u_prio_enc (
        .req   (dl_detect_vec),
        .idx   (enc_idx),
        .found (enc_found)
    );

`ifdef PASS_HLS_DL_REPORT_TIMEOUT_EN
    localparam int TRACE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TRACE_W-1:0] trace_cnt;
    logic               timeout_pulse;
    assign dl_timeout = timeout_pulse;
`else
    assign dl_timeout = 1'b0;
`endif

    // The loop closes the moment the candidate re-flags during the trace.
    assign token_clear = (state == ST_TRACE) && dl_detect_vec[cand];

    // Sequencer: state plus registered outputs updated alongside each transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            cand            <= '0;
            conf_cnt        <= '0;
            path            <= '0;
            dl_detect_in    <= 1'b0;
            origin_vec      <= '0;
            report_valid    <= 1'b0;
            report_proc_id  <= '0;
            report_path_vec <= '0;
`ifdef PASS_HLS_DL_REPORT_TIMEOUT_EN
            trace_cnt       <= '0;
            timeout_pulse   <= 1'b0;
`endif
        end else begin
            origin_vec <= '0;
`ifdef PASS_HLS_DL_REPORT_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (enc_found) begin
                        cand     <= enc_idx;
                        conf_cnt <= '0;
                        state    <= ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (!dl_detect_vec[cand]) begin
                        state <= ST_IDLE;
                    end else if (conf_cnt == CONF_W'(CONFIRM_CYCLES - 1)) begin
                        state        <= ST_ORIGIN;
                        dl_detect_in <= 1'b1;
                        origin_vec   <= PROC_NUM'(1) << cand;
                    end else begin
                        conf_cnt <= conf_cnt + CONF_W'(1);
                    end
                end
                ST_ORIGIN: begin
                    path  <= '0;
                    state <= ST_TRACE;
`ifdef PASS_HLS_DL_REPORT_TIMEOUT_EN
                    trace_cnt <= '0;
`endif
                end
                ST_TRACE: begin
                    path <= path | dl_detect_vec;
                    // Closure is checked first so it wins on the final timeout cycle.
                    if (dl_detect_vec[cand]) begin
                        state           <= ST_REPORT;
                        report_valid    <= 1'b1;
                        report_proc_id  <= cand;
                        report_path_vec <= path | dl_detect_vec;
`ifdef PASS_HLS_DL_REPORT_TIMEOUT_EN
                    end else if (trace_cnt == TRACE_W'(TIMEOUT_CYCLES - 1)) begin
                        state         <= ST_IDLE;
                        dl_detect_in  <= 1'b0;
                        timeout_pulse <= 1'b1;
                    end else begin
                        trace_cnt <= trace_cnt + TRACE_W'(1);
`endif
                    end
                end
                ST_REPORT: begin
                    if (report_ack) begin
                        state           <= ST_IDLE;
                        dl_detect_in    <= 1'b0;
                        report_valid    <= 1'b0;
                        report_proc_id  <= '0;
                        report_path_vec <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
